// File: rtl/mem_addr_sequencer_if.sv
// Memory-side bus between the address sequencer and the unified I/D memory.
// The master (sequencer) drives address, request and write strobe; the slave
// (memory) answers with mem_ready to complete the transaction in flight.
//   mem_addr  : transaction address, stable while mem_req is high
//   mem_req   : a transaction is being requested
//   mem_we    : write strobe, 0 for instruction fetches
//   mem_ready : memory completes the current transaction this cycle
interface mem_addr_sequencer_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_req;
  logic                  mem_we;
  logic                  mem_ready;

  modport master (
    output mem_addr,
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/mem_addr_sequencer.sv
// Purpose: owns the PC and issues one memory transaction at a time (fetch at PC or data at alu_out).
// Latency: request sampled in IDLE -> mem_req next cycle; done pulses the cycle after mem_ready (min 2 cycles).
// Backpressure: BUSY holds address/strobes stable until mem_ready; new requests are ignored while busy.
//
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   fetch_req      : start an instruction fetch at PC (IDLE only, wins over data_req)
//   data_req       : start a data access at alu_out[ADDR_WIDTH-1:0] (IDLE only)
//   data_we        : write flag of the data access, captured with data_req
//   alu_out        : ALU result, used as data address or PC load value
//   jump_target    : PC load value for pc_src = 2'b10
//   pc_src         : 00 PC+PC_INC, 01 alu_out, 10 jump_target, 11 hold
//   pc_write       : load PC from pc_src this cycle (any state)
//   mem            : memory bus (master side)
//   iord           : 0 = current/last transaction is a fetch, 1 = data access
//   busy           : a transaction is in flight
//   done           : one-cycle completion pulse
//   pc_out         : current PC register
//   timeout_err    : one-cycle pulse when a transaction is abandoned
//
// Optional feature macro: ADDR_TIMEOUT_EN
//   defined   : a transaction waiting TIMEOUT_CYCLES BUSY cycles without mem_ready
//               is dropped with a timeout_err pulse (no done, no PC increment)
//   undefined : BUSY waits indefinitely and timeout_err is constant 0
module mem_addr_sequencer #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int PC_INC         = 1,
  parameter int RESET_PC       = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_req,
  input  logic                   data_req,
  input  logic                   data_we,
  input  logic [DATA_WIDTH-1:0]  alu_out,
  input  logic [ADDR_WIDTH-1:0]  jump_target,
  input  logic [1:0]             pc_src,
  input  logic                   pc_write,
  mem_addr_sequencer_if.master   mem,
  output logic                   iord,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic                   timeout_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_RST  = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INC);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  req_q,   req_d;
  logic                  we_q,    we_d;
  logic                  iord_q,  iord_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic [ADDR_WIDTH-1:0] pc_q,    pc_d;
  logic                  terr_q,  terr_d;

  // Only the low address bits of the ALU result ever reach the bus or the PC.
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic                  unused_alu_hi;
  assign alu_addr      = alu_out[ADDR_WIDTH-1:0];
  assign unused_alu_hi = ^alu_out[DATA_WIDTH-1:ADDR_WIDTH];

  // Asserted in the BUSY cycle where a fetch is accepted by memory.
  logic fetch_done;

`ifdef ADDR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire;

  // The counter holds the number of BUSY cycles already spent without
  // mem_ready; the cycle in which it would reach the limit is the last one.
  assign expire = (state_q == ST_BUSY) && !mem.mem_ready && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (!mem.mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic expire;
  logic unused_timeout_cfg;
  assign expire             = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Transaction FSM: next state and registered bus outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_d      = req_q;
    we_d       = we_q;
    iord_d     = iord_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    terr_d     = 1'b0;
    fetch_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          state_d = ST_BUSY;
          addr_d  = pc_q;
          iord_d  = 1'b0;
          we_d    = 1'b0;
          req_d   = 1'b1;
          busy_d  = 1'b1;
        end else if (data_req) begin
          state_d = ST_BUSY;
          addr_d  = alu_addr;
          iord_d  = 1'b1;
          we_d    = data_we;
          req_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_BUSY: begin
        // mem_ready is checked before the timeout so a late acceptance on
        // the limit cycle still completes normally.
        if (mem.mem_ready) begin
          state_d    = ST_IDLE;
          req_d      = 1'b0;
          we_d       = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          fetch_done = !iord_q;
        end else if (expire) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          terr_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // PC update: an explicit load beats the auto-increment of a completing fetch.
  always_comb begin
    pc_d = pc_q;
    if (pc_write && (pc_src != 2'b11)) begin
      unique case (pc_src)
        2'b00:   pc_d = pc_q + PC_STEP;
        2'b01:   pc_d = alu_addr;
        2'b10:   pc_d = jump_target;
        default: pc_d = pc_q;
      endcase
    end else if (fetch_done) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      iord_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pc_q    <= PC_RST;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      iord_q  <= iord_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pc_q    <= pc_d;
      terr_q  <= terr_d;
    end
  end

  assign mem.mem_addr = addr_q;
  assign mem.mem_req  = req_q;
  assign mem.mem_we   = we_q;
  assign iord         = iord_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pc_out       = pc_q;
  assign timeout_err  = terr_q;

endmodule

// File: doc/mem_addr_sequencer.md
Name: mem_addr_sequencer

Overview:
Registered successor to the combinational PC/ALU address mux of the multicycle datapath. Owns the program counter and issues one memory transaction at a time, either an instruction fetch at PC or a data access at the ALU result. Runs a req/ready handshake with memory and auto-increments PC on fetch completion. Sits between the control FSM and the unified instruction/data memory.

Parameters:
ADDR_WIDTH, 16, memory address and PC width
DATA_WIDTH, 32, ALU result width; only bits [ADDR_WIDTH-1:0] are used as an address
PC_INC, 1, PC increment applied on fetch completion (word-addressed memory)
RESET_PC, 0, PC value after reset
TIMEOUT_CYCLES, 16, wait limit in cycles; used only with ADDR_TIMEOUT_EN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  start instruction fetch at PC (sampled in IDLE only)
data_req  in  1  start data access at alu_out (sampled in IDLE only)
data_we  in  1  write flag for the data access, latched with data_req
alu_out  in  DATA_WIDTH  ALU result: data address or branch target
jump_target  in  ADDR_WIDTH  jump destination
pc_src  in  2  PC load source: 00 = PC+PC_INC, 01 = alu_out[ADDR_WIDTH-1:0], 10 = jump_target, 11 = hold
pc_write  in  1  load PC from pc_src this cycle
mem_ready  in  1  memory completes the current transaction
mem_addr  out  ADDR_WIDTH  registered transaction address
mem_req  out  1  transaction request
mem_we  out  1  write strobe; 0 for fetches
iord  out  1  0 = current or last transaction is a fetch, 1 = data access
busy  out  1  a transaction is in flight
done  out  1  one-cycle completion pulse
pc_out  out  ADDR_WIDTH  current PC
timeout_err  out  1  one-cycle timeout pulse; tied 0 without ADDR_TIMEOUT_EN

Behaviour:
- Reset (async, rst_n low): PC = RESET_PC; state IDLE; mem_addr = 0; mem_req, mem_we, iord, busy, done, timeout_err = 0. Reset mid-transaction aborts it immediately, with no done and no PC increment.
- FSM states are IDLE and BUSY.
- IDLE, fetch_req = 1: next cycle, mem_addr = PC, iord = 0, mem_we = 0, mem_req = 1, busy = 1, state = BUSY.
- IDLE, data_req = 1 and fetch_req = 0: mem_addr = alu_out[ADDR_WIDTH-1:0], iord = 1, mem_we = data_we, mem_req = 1, busy = 1, state = BUSY.
- fetch_req has priority when both requests are asserted together.
- In BUSY, fetch_req and data_req are ignored. mem_addr, mem_we and iord stay stable while mem_req is high.
- BUSY, mem_ready = 1: next cycle, mem_req = 0, mem_we = 0, busy = 0, done = 1 for one cycle, state = IDLE. iord holds its value until the next request.
- Minimum latency from request to done is 2 cycles; mem_ready may already be high in the first BUSY cycle.
- A fetch completion sets PC = PC + PC_INC, modulo 2^ADDR_WIDTH (wraps at the top of the address space).
- pc_write = 1 with pc_src != 11 loads PC in any state. If it coincides with fetch completion, pc_write wins and no auto-increment is applied.
- Loads with pc_src = 00 use the current PC. pc_src = 11 leaves PC unchanged.
- Upper bits alu_out[DATA_WIDTH-1:ADDR_WIDTH] are ignored.
- pc_out reflects the PC register directly, with no extra latency.

Optional Feature:
ADDR_TIMEOUT_EN
- Defined: a counter clears when BUSY is entered and increments each BUSY cycle without mem_ready. If it reaches TIMEOUT_CYCLES, the next cycle drops mem_req, pulses timeout_err for one cycle, returns to IDLE, gives no done and no PC increment. mem_ready in the same cycle as the limit counts as success.
- Undefined: no counter; BUSY waits indefinitely; timeout_err is constant 0.

Test Plan:
- Reset, then fetch_req with mem_ready high in the first BUSY cycle -> mem_addr = 0x0000, iord = 0; done pulses 2 cycles after the request; pc_out = 0x0001.
- data_req with alu_out = 0xDEAD1234, data_we = 1, mem_ready after 3 wait cycles -> mem_addr = 0x1234, mem_we = 1 and iord = 1 held stable; PC unchanged.
- fetch_req and data_req asserted together -> fetch serviced first; the data_req reissued later is serviced after done.
- PC = 0xFFFF, fetch completes -> pc_out = 0x0000. pc_write with pc_src = 10, jump_target = 0x0040 on the completion cycle -> pc_out = 0x0040 (not 0x0041).
- rst_n low during BUSY -> all outputs clear at once, pc_out = RESET_PC, no done.
- With ADDR_TIMEOUT_EN, mem_ready held low -> timeout_err pulses after 16 BUSY cycles, busy = 0, PC unchanged.
